// File: rtl/sisc_stat_unit.sv
// SISC status unit: latches ALU CVNZ status, evaluates branch conditions against it,
// and keeps a small save/restore stack of status words for interrupt entry/return.
module sisc_stat_unit #(
    parameter int DEPTH = 4,
    parameter bit FWD   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_f,
    input  logic [3:0] stat,
    input  logic       stat_en,
    input  logic       br_req,
    input  logic [3:0] br_cc,
    input  logic       br_neg,
    input  logic       sv_push,
    input  logic       sv_pop,
    output logic [3:0] stat_q,
    output logic       br_valid,
    output logic       br_taken,
    output logic [4:0] stk_cnt,
    output logic       stk_err
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    logic [3:0]    stk_mem_r [DEPTH];
    logic [3:0]    stat_d_s;
    logic [4:0]    cnt_d_s;
    logic [4:0]    cnt_m1_s;
    logic          err_d_s;
    logic          wr_en_s;
    logic [AW-1:0] wr_idx_s;
    logic [AW-1:0] rd_idx_s;
    logic [3:0]    src_s;
    logic          hit_s;

    // Next-state decode for status register and stack, in push/pop priority order
    always_comb begin
        cnt_m1_s = stk_cnt - 5'd1;
        wr_idx_s = stk_cnt[AW-1:0];
        rd_idx_s = cnt_m1_s[AW-1:0];
        stat_d_s = stat_en ? stat : stat_q;
        cnt_d_s  = stk_cnt;
        err_d_s  = stk_err;
        wr_en_s  = 1'b0;
        if (sv_push && sv_pop) begin
            err_d_s = 1'b1;
        end else if (sv_pop) begin
            if (stk_cnt != 5'd0) begin
                // restored word overrides any concurrent stat_en write
                stat_d_s = stk_mem_r[rd_idx_s];
                cnt_d_s  = cnt_m1_s;
            end else begin
                err_d_s = 1'b1;
            end
        end else if (sv_push) begin
            if (stk_cnt < DEPTH_C) begin
                wr_en_s = 1'b1;
                cnt_d_s = stk_cnt + 5'd1;
            end else begin
                err_d_s = 1'b1;
            end
        end else begin
            cnt_d_s = stk_cnt;
        end
    end

    // Branch condition against the pre-update (optionally forwarded) status
    always_comb begin
        if (FWD && stat_en) begin
            src_s = stat;
        end else begin
            src_s = stat_q;
        end
        hit_s = |(br_cc & src_s);
    end

    // Status register, stack count and sticky fault flag
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            stat_q  <= 4'd0;
            stk_cnt <= 5'd0;
            stk_err <= 1'b0;
        end else begin
            stat_q  <= stat_d_s;
            stk_cnt <= cnt_d_s;
            stk_err <= err_d_s;
        end
    end

    // Save-stack storage; a push stores the status value from before this edge
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            for (int i = 0; i < DEPTH; i++) begin
                stk_mem_r[i] <= 4'd0;
            end
        end else if (wr_en_s) begin
            stk_mem_r[wr_idx_s] <= stat_q;
        end else begin
            stk_mem_r[wr_idx_s] <= stk_mem_r[wr_idx_s];
        end
    end

    // Branch result: one-cycle valid pulse, decision held until the next request
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            br_valid <= 1'b0;
            br_taken <= 1'b0;
        end else if (br_req) begin
            br_valid <= 1'b1;
            br_taken <= hit_s ^ br_neg;
        end else begin
            br_valid <= 1'b0;
        end
    end

endmodule
